multi_debouncer: RTL and testbench

- Parametrised N-channel push-button conditioner; successor to the single-input one-shot FSM.
- Per channel:
  - synchronises the raw asynchronous input;
  - filters bounce with a stable-sample counter;
  - produces a clean level plus one-cycle press and release pulses;
  - optionally produces auto-repeat pulses while the button is held.
- Sits between board push-buttons and the control FSMs; one instance serves the whole keypad.

---
 rtl/multi_debouncer.sv | 216 +++++++++++++++++++++
 tb/tb_multi_debouncer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_debouncer.sv
// -----------------------------------------------------------------------------
// multi_debouncer
//
// N-channel push-button conditioner. Every channel is an independent
// debounce_lane: two-flop synchroniser, stable-sample filter that advances
// only on tick, registered press/release pulses and an optional auto-repeat
// generator that fires while the button is held.
//
// Ports
//   clk            system clock
//   reset          asynchronous, active-high reset (all state to 0)
//   tick           sample-enable strobe; filter and repeat counters only
//                  advance on clk edges with tick=1
//   raw[N]         asynchronous button inputs, active-high
//   level[N]       debounced level per channel
//   press[N]       one-clk pulse on accepted 0->1 of level
//   release_pulse[N] one-clk pulse on accepted 1->0 of level
//   repeat_pulse[N]  one-clk auto-repeat pulse while held
//   any_press      OR of the press bits, registered on the same edge
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// debounce_lane
//
// One channel of the conditioner.
//
// Ports
//   clk, reset, tick   as in the top level
//   raw                asynchronous button input
//   level              debounced level
//   press              one-clk pulse when level is accepted high
//   release_pulse      one-clk pulse when level is accepted low
//   repeat_pulse       one-clk auto-repeat pulse
//   press_next         value press takes on the coming edge; lets the top
//                      level register any_press alongside press
// -----------------------------------------------------------------------------
module debounce_lane #(
  parameter int STABLE_TICKS = 4,
  parameter int REPEAT_EN    = 1,
  parameter int HOLD_TICKS   = 500,
  parameter int REPEAT_TICKS = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic press_next
);

  localparam int CW   = $clog2(STABLE_TICKS + 1);
  localparam int HMAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int HCW  = $clog2(HMAX + 1);

  // ---------------------------------------------------------------------------
  // Synchroniser: runs every clk, independent of tick.
  // ---------------------------------------------------------------------------
  logic s1, s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stable-sample filter. cnt counts consecutive tick samples that disagree
  // with the current level; any agreeing sample clears it, so a disturbance
  // shorter than STABLE_TICKS ticks never reaches level.
  // ---------------------------------------------------------------------------
  logic [CW-1:0] cnt;
  logic          differ;
  logic          accept;
  logic          fall;

  assign differ     = s2 ^ level;
  assign accept     = tick & differ & (cnt == CW'(STABLE_TICKS - 1));
  assign press_next = accept & ~level;
  assign fall       = accept & level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level         <= 1'b0;
      cnt           <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      // Pulses are registered on the same edge that moves level; the filter
      // needs STABLE_TICKS ticks between changes, so they self-clear.
      press         <= press_next;
      release_pulse <= fall;
      if (tick) begin
        if (!differ) begin
          cnt <= '0;
        end else if (accept) begin
          level <= s2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Auto-repeat. Decisions use the pre-edge level: the press edge itself sees
  // level=0 and clears hc, so the first repeat lands exactly HOLD_TICKS ticks
  // after press. IDLE with level=1 (the first tick after press) behaves as
  // HOLD. A press can only occur with level=0 and a repeat only with level=1,
  // so the two never coincide on a channel.
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RPT  = 2'd2
  } rpt_state_t;

  if (REPEAT_EN != 0) begin : g_rpt
    rpt_state_t     state;
    logic [HCW-1:0] hc;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state        <= IDLE;
        hc           <= '0;
        repeat_pulse <= 1'b0;
      end else begin
        repeat_pulse <= 1'b0;
        if (tick) begin
          if (!level || fall) begin
            // Released, or releasing on this very edge: no pulse, restart.
            state <= IDLE;
            hc    <= '0;
          end else if (state == RPT) begin
            if (hc == HCW'(REPEAT_TICKS - 1)) begin
              repeat_pulse <= 1'b1;
              hc           <= '0;
            end else begin
              hc <= hc + HCW'(1);
            end
          end else begin
            if (hc == HCW'(HOLD_TICKS - 1)) begin
              repeat_pulse <= 1'b1;
              hc           <= '0;
              state        <= RPT;
            end else begin
              hc    <= hc + HCW'(1);
              state <= HOLD;
            end
          end
        end
      end
    end
  end else begin : g_no_rpt
    assign repeat_pulse = 1'b0;
  end

endmodule

// -----------------------------------------------------------------------------
// Top level: one lane per channel plus the shared any_press register.
// -----------------------------------------------------------------------------
module multi_debouncer #(
  parameter int N            = 4,
  parameter int STABLE_TICKS = 4,
  parameter int REPEAT_EN    = 1,
  parameter int HOLD_TICKS   = 500,
  parameter int REPEAT_TICKS = 100
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic [N-1:0] raw,
  output logic [N-1:0] level,
  output logic [N-1:0] press,
  output logic [N-1:0] release_pulse,
  output logic [N-1:0] repeat_pulse,
  output logic         any_press
);

  logic [N-1:0] press_next;

  for (genvar i = 0; i < N; i++) begin : g_lane
    debounce_lane #(
      .STABLE_TICKS (STABLE_TICKS),
      .REPEAT_EN    (REPEAT_EN),
      .HOLD_TICKS   (HOLD_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS)
    ) u_lane (
      .clk           (clk),
      .reset         (reset),
      .tick          (tick),
      .raw           (raw[i]),
      .level         (level[i]),
      .press         (press[i]),
      .release_pulse (release_pulse[i]),
      .repeat_pulse  (repeat_pulse[i]),
      .press_next    (press_next[i])
    );
  end

  // Registered from the lanes' next-press terms so it is high on exactly the
  // cycles where some press bit is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) any_press <= 1'b0;
    else       any_press <= |press_next;
  end

endmodule

// File: tb/tb_multi_debouncer.sv
module tb_multi_debouncer;

  localparam int N    = 4;
  localparam int ST   = 4;
  localparam int HOLD = 5;
  localparam int REP  = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         tick;
  logic [N-1:0] raw;
  logic [N-1:0] level, press, rls, rpt;
  logic         any_press;

  int checks = 0;
  int errors = 0;

  multi_debouncer #(
    .N(N), .STABLE_TICKS(ST), .REPEAT_EN(1), .HOLD_TICKS(HOLD), .REPEAT_TICKS(REP)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .raw(raw),
    .level(level), .press(press), .release_pulse(rls), .repeat_pulse(rpt),
    .any_press(any_press)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model. raw reaches the filter two edges late; a new level is
  // accepted when ST consecutive tick samples show the opposite value; the
  // repeat schedule is computed from the number of held ticks since press.
  // ---------------------------------------------------------------------------
  logic [N-1:0] hist[$];
  logic [N-1:0] m_level, exp_press, exp_rel, exp_rpt;
  logic         exp_any;
  int           run[N];
  int           held[N];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hist.delete();
      hist.push_back('0);
      hist.push_back('0);
      m_level = '0; exp_press = '0; exp_rel = '0; exp_rpt = '0; exp_any = 1'b0;
      for (int c = 0; c < N; c++) begin run[c] = 0; held[c] = 0; end
    end else begin
      logic [N-1:0] smp;
      smp = hist.pop_front();
      hist.push_back(raw);
      exp_press = '0; exp_rel = '0; exp_rpt = '0;
      if (tick) begin
        for (int c = 0; c < N; c++) begin
          logic pre, chg;
          pre = m_level[c];
          chg = 1'b0;
          if (smp[c] != pre) begin
            run[c]++;
            if (run[c] == ST) begin chg = 1'b1; run[c] = 0; end
          end else run[c] = 0;
          if (chg) begin
            m_level[c] = ~pre;
            if (pre) exp_rel[c] = 1'b1; else exp_press[c] = 1'b1;
          end
          if (pre && !chg) begin
            held[c]++;
            if (held[c] == HOLD || (held[c] > HOLD && (held[c] - HOLD) % REP == 0))
              exp_rpt[c] = 1'b1;
          end else held[c] = 0;
        end
      end
      exp_any = |exp_press;
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1; raw = '0; tick = 1'b1;
    #1;
    checks++;
    if ({level, press, rls, rpt, any_press} !== '0) begin
      errors++; $display("FAIL reset_async got=%b want=0", {level, press, rls, rpt, any_press});
    end
    repeat (3) cyc();
    checks++;
    if ({level, press, rls, rpt, any_press} !== '0) begin
      errors++; $display("FAIL reset_held got=%b want=0", {level, press, rls, rpt, any_press});
    end
    reset = 1'b0;
    repeat (10) cyc();
  endtask

  task automatic test_clean_press();
    raw = '0; tick = 1'b1;
    repeat (10) cyc();
    raw[0] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      cyc();
      checks++;
      if ({level, press, rls, rpt, any_press} !== {m_level, exp_press, exp_rel, exp_rpt, exp_any}) begin
        errors++; $display("FAIL model_clean e=%0d got=%b want=%b", e,
          {level, press, rls, rpt, any_press}, {m_level, exp_press, exp_rel, exp_rpt, exp_any});
      end
      if (e < 6) begin
        checks++;
        if (level !== 4'b0000) begin errors++; $display("FAIL clean_early e=%0d level=%b want=0000", e, level); end
      end
      if (e == 6) begin
        checks++;
        if (level !== 4'b0001 || press !== 4'b0001 || any_press !== 1'b1) begin
          errors++; $display("FAIL clean_edge6 level=%b press=%b any=%b want 0001/0001/1", level, press, any_press);
        end
      end
      if (e == 7) begin
        checks++;
        if (level !== 4'b0001 || press !== 4'b0000 || any_press !== 1'b0) begin
          errors++; $display("FAIL clean_edge7 level=%b press=%b any=%b want 0001/0000/0", level, press, any_press);
        end
      end
    end
  endtask

  task automatic test_bounce();
    logic [7:0] pat;
    int npress, at;
    pat = 8'b0011_0011;
    npress = 0; at = -1;
    for (int e = 1; e <= 25; e++) begin
      raw[1] = (e <= 8) ? pat[e-1] : 1'b1;
      cyc();
      checks++;
      if ({level, press, rls, rpt, any_press} !== {m_level, exp_press, exp_rel, exp_rpt, exp_any}) begin
        errors++; $display("FAIL model_bounce e=%0d got=%b want=%b", e,
          {level, press, rls, rpt, any_press}, {m_level, exp_press, exp_rel, exp_rpt, exp_any});
      end
      if (press[1]) begin npress++; at = e; end
    end
    checks++;
    if (npress != 1 || at != 14) begin
      errors++; $display("FAIL bounce_press count=%0d edge=%0d want 1 at 14", npress, at);
    end
  endtask

  task automatic test_repeat();
    int ep;
    raw = '0; tick = 1'b1;
    repeat (20) cyc();
    raw[2] = 1'b1;
    ep = -1;
    for (int e = 1; e <= 40; e++) begin
      cyc();
      checks++;
      if ({level, press, rls, rpt, any_press} !== {m_level, exp_press, exp_rel, exp_rpt, exp_any}) begin
        errors++; $display("FAIL model_repeat e=%0d got=%b want=%b", e,
          {level, press, rls, rpt, any_press}, {m_level, exp_press, exp_rel, exp_rpt, exp_any});
      end
      if (press[2] && ep < 0) ep = e;
      if (ep >= 0 && e > ep) begin
        logic want;
        want = (e == ep + 5) || (e == ep + 7) || (e == ep + 9);
        checks++;
        if (rpt[2] !== want) begin
          errors++; $display("FAIL repeat_sched e=%0d (press+%0d) got=%b want=%b", e, e - ep, rpt[2], want);
        end
        if (e == ep + 11) begin
          checks++;
          if (rls[2] !== 1'b1) begin errors++; $display("FAIL repeat_release got=%b want=1", rls[2]); end
        end
        // Dropping now makes the fall coincide with a would-be repeat edge.
        if (e == ep + 5) raw[2] = 1'b0;
      end
    end
    checks++;
    if (ep != 6) begin errors++; $display("FAIL repeat_press_edge got=%0d want=6", ep); end
  endtask

  task automatic test_tick_gating();
    logic [N-1:0] prev;
    int rise_at;
    raw = '0; tick = 1'b1;
    repeat (20) cyc();
    prev = level; rise_at = -1;
    raw[3] = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      tick = (e % 3 == 0);
      cyc();
      checks++;
      if ({level, press, rls, rpt, any_press} !== {m_level, exp_press, exp_rel, exp_rpt, exp_any}) begin
        errors++; $display("FAIL model_tick e=%0d got=%b want=%b", e,
          {level, press, rls, rpt, any_press}, {m_level, exp_press, exp_rel, exp_rpt, exp_any});
      end
      if (!tick) begin
        checks++;
        if (level !== prev || rpt !== '0) begin
          errors++; $display("FAIL tick_frozen e=%0d level=%b prev=%b rpt=%b", e, level, prev, rpt);
        end
      end
      if (level[3] && !prev[3]) rise_at = e;
      prev = level;
    end
    checks++;
    if (rise_at != 12) begin errors++; $display("FAIL tick_rise_edge got=%0d want=12", rise_at); end
    tick = 1'b1;
  endtask

  task automatic test_simultaneous();
    raw = '0; tick = 1'b1;
    repeat (20) cyc();
    raw[0] = 1'b1; raw[3] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      cyc();
      checks++;
      if ({level, press, rls, rpt, any_press} !== {m_level, exp_press, exp_rel, exp_rpt, exp_any}) begin
        errors++; $display("FAIL model_simul e=%0d got=%b want=%b", e,
          {level, press, rls, rpt, any_press}, {m_level, exp_press, exp_rel, exp_rpt, exp_any});
      end
      if (e == 6) begin
        checks++;
        if (press !== 4'b1001 || any_press !== 1'b1) begin
          errors++; $display("FAIL simul_press press=%b any=%b want 1001/1", press, any_press);
        end
      end
      if (e == 7) begin
        checks++;
        if (press !== 4'b0000 || any_press !== 1'b0) begin
          errors++; $display("FAIL simul_after press=%b any=%b want 0000/0", press, any_press);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    raw = '0; tick = 1'b1;
    repeat (20) cyc();
    raw[2] = 1'b1;
    repeat (14) cyc();   // press at 6, repeats at 11 and 13: now in the RPT phase
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({level, press, rls, rpt, any_press} !== '0) begin
      errors++; $display("FAIL reset_mid got=%b want=0", {level, press, rls, rpt, any_press});
    end
    repeat (2) cyc();
    reset = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      cyc();
      checks++;
      if ({level, press, rls, rpt, any_press} !== {m_level, exp_press, exp_rel, exp_rpt, exp_any}) begin
        errors++; $display("FAIL model_rstmid e=%0d got=%b want=%b", e,
          {level, press, rls, rpt, any_press}, {m_level, exp_press, exp_rel, exp_rpt, exp_any});
      end
      checks++;
      if (press[2] !== (e == 6) || rpt[2] !== (e == 11 || e == 13 || e == 15)) begin
        errors++; $display("FAIL rstmid_sched e=%0d press=%b rpt=%b", e, press[2], rpt[2]);
      end
    end
  endtask

  task automatic test_random();
    for (int e = 1; e <= 1500; e++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 7) == 0) raw[c] = ~raw[c];
      tick = ($urandom_range(0, 3) != 0);
      cyc();
      checks++;
      if ({level, press, rls, rpt, any_press} !== {m_level, exp_press, exp_rel, exp_rpt, exp_any}) begin
        errors++; $display("FAIL model_random e=%0d got=%b want=%b", e,
          {level, press, rls, rpt, any_press}, {m_level, exp_press, exp_rel, exp_rpt, exp_any});
      end
    end
    tick = 1'b1;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_repeat();
    test_tick_gating();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
